// File: rtl/r6_column_tap_gen.sv
// r6_column_tap_gen: raster pixel stream in, 13-tap vertical column out.
// Twelve line buffers hold the previous rows. Each accepted pixel emits the
// column ending at that pixel. Rows that do not exist yet read as zero.
// Optional build macro R6_TAP_FLUSH_EN appends 6*COLS zero-pixel columns
// after each frame, which gives bottom-edge padding.
module r6_column_tap_gen #(
    parameter int COLS = 15,
    parameter int ROWS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_i,
    input  logic [7:0] pixel_i,
    output logic [7:0] S1,
    output logic [7:0] S2,
    output logic [7:0] S3,
    output logic [7:0] S4,
    output logic [7:0] S5,
    output logic [7:0] S6,
    output logic [7:0] S7,
    output logic [7:0] S8,
    output logic [7:0] S9,
    output logic [7:0] S10,
    output logic [7:0] S11,
    output logic [7:0] S12,
    output logic [7:0] S13,
    output logic       done_o,
    output logic       progress_done_o
);

    localparam int unsigned NTAP = 13;
    localparam int unsigned NLB  = 12;
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
`ifdef R6_TAP_FLUSH_EN
    localparam int unsigned LAST_ROW = ROWS + 5;
`else
    localparam int unsigned LAST_ROW = ROWS - 1;
`endif
    localparam int unsigned RW   = $clog2(LAST_ROW + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
`ifdef R6_TAP_FLUSH_EN
        ,
        FLUSH  = 2'd3
`endif
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic            accept;
    logic [7:0]      pix_eff;
    logic            col_last;
    logic            row_frame_last;
    logic            row_flush_last;
    logic [NLB-1:0]  tap_ok;
    logic [7:0]      tap_q [NTAP];
    logic [7:0]      lb    [NLB][COLS];

    assign col_last       = (col_cnt == CW'(COLS - 1));
    assign row_frame_last = (row_cnt == RW'(ROWS - 1));
    assign row_flush_last = (row_cnt == RW'(LAST_ROW));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, accept decision and the pixel value fed to the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        pix_eff = pixel_i;
        case (state_q)
            IDLE, DONE: begin
                if (done_i) begin
                    accept  = 1'b1;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (done_i) begin
                    accept = 1'b1;
                    if (col_last && row_frame_last) begin
`ifdef R6_TAP_FLUSH_EN
                        state_d = FLUSH;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef R6_TAP_FLUSH_EN
            FLUSH: begin
                accept  = 1'b1;
                pix_eff = 8'd0;
                if (col_last && row_flush_last) begin
                    state_d = DONE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Tap k (S(13-k)) is valid only once row r-k exists in this frame.
    always_comb begin
        tap_ok = '0;
        for (int i = 0; i < int'(NLB); i++) begin
            tap_ok[i] = (32'(row_cnt) >= 32'(int'(NLB) - i));
        end
    end

    // Raster counters; cleared at frame end so a DONE-cycle pixel is (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_last) begin
                col_cnt <= '0;
                if (state_d == DONE) begin
                    row_cnt <= '0;
                end else begin
                    row_cnt <= row_cnt + RW'(1);
                end
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    // Registered taps and strobes; taps hold when nothing is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NTAP); i++) begin
                tap_q[i] <= 8'd0;
            end
            done_o          <= 1'b0;
            progress_done_o <= 1'b0;
        end else begin
            done_o          <= accept;
            progress_done_o <= accept && (state_d == DONE);
            if (accept) begin
                tap_q[NTAP-1] <= pix_eff;
                for (int i = 0; i < int'(NLB); i++) begin
                    tap_q[i] <= tap_ok[i] ? lb[i][col_cnt] : 8'd0;
                end
            end
        end
    end

    // Line buffers shift one row older per accepted column (read before write).
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < int'(NLB) - 1; j++) begin
                lb[j][col_cnt] <= lb[j+1][col_cnt];
            end
            lb[NLB-1][col_cnt] <= pix_eff;
        end
    end

    assign S1  = tap_q[0];
    assign S2  = tap_q[1];
    assign S3  = tap_q[2];
    assign S4  = tap_q[3];
    assign S5  = tap_q[4];
    assign S6  = tap_q[5];
    assign S7  = tap_q[6];
    assign S8  = tap_q[7];
    assign S9  = tap_q[8];
    assign S10 = tap_q[9];
    assign S11 = tap_q[10];
    assign S12 = tap_q[11];
    assign S13 = tap_q[12];

endmodule

// File: tb/tb_r6_column_tap_gen.sv
// Testbench for r6_column_tap_gen: random and patterned raster stimulus,
// a frame-image reference model and a queue-based scoreboard.
module tb_r6_column_tap_gen;

    localparam int COLS = 15;
    localparam int ROWS = 15;
    localparam int NFL  = 6 * COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       done_i = 1'b0;
    logic [7:0] pixel_i = 8'd0;
    logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9, S10, S11, S12, S13;
    logic       done_o;
    logic       progress_done_o;

    r6_column_tap_gen #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk             (clk),
        .rst             (rst),
        .done_i          (done_i),
        .pixel_i         (pixel_i),
        .S1              (S1),
        .S2              (S2),
        .S3              (S3),
        .S4              (S4),
        .S5              (S5),
        .S6              (S6),
        .S7              (S7),
        .S8              (S8),
        .S9              (S9),
        .S10             (S10),
        .S11             (S11),
        .S12             (S12),
        .S13             (S13),
        .done_o          (done_o),
        .progress_done_o (progress_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [12:0][7:0] t;
        logic             prog;
        logic [31:0]      at;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               errors = 0;
    logic [7:0]       img [ROWS+6][COLS];
    int               mr = 0;
    int               mc = 0;
    int               flush_left = 0;
    int               frame_cnt = 0;
    logic [12:0][7:0] last_t = '0;
    logic [12:0][7:0] dut_t;

    assign dut_t = {S13, S12, S11, S10, S9, S8, S7, S6, S5, S4, S3, S2, S1};

    task automatic chk(input string nm, input logic [103:0] got, input logic [103:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    // Column ending at (r,c): row r-k of the current frame, or 0 above the top.
    function automatic logic [12:0][7:0] model_taps(input int r, input int c);
        logic [12:0][7:0] t;
        t = '0;
        for (int k = 0; k < 13; k++) begin
            if (r - k >= 0) t[12-k] = img[r-k][c];
        end
        return t;
    endfunction

    task automatic model_accept(input logic [7:0] p);
        exp_t e;
        bit   last;
        img[mr][mc] = p;
        last = (mr == ROWS - 1) && (mc == COLS - 1);
        e.t  = model_taps(mr, mc);
        e.at = 32'(cyc + 1);
`ifdef R6_TAP_FLUSH_EN
        e.prog = 1'b0;
`else
        e.prog = last;
`endif
        q.push_back(e);
        if (last) begin
            frame_cnt++;
`ifdef R6_TAP_FLUSH_EN
            for (int r = ROWS; r < ROWS + 6; r++)
                for (int c = 0; c < COLS; c++) img[r][c] = 8'd0;
            for (int n = 0; n < NFL; n++) begin
                e.t    = model_taps(ROWS + n / COLS, n % COLS);
                e.prog = (n == NFL - 1);
                e.at   = 32'(cyc + 2 + n);
                q.push_back(e);
            end
            flush_left = NFL;
`endif
            mr = 0;
            mc = 0;
        end else if (mc == COLS - 1) begin
            mc = 0;
            mr++;
        end else begin
            mc++;
        end
    endtask

    // One cycle of stimulus; during a flush the DUT ignores done_i.
    task automatic send(input logic v, input logic [7:0] p);
        @(negedge clk);
        done_i  = v;
        pixel_i = p;
        if (flush_left > 0) flush_left--;
        else if (v) model_accept(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst    = 1'b0;
        done_i = 1'b0;
        #1;
        chk("reset_taps", 104'(dut_t), 104'(0));
        chk("reset_done", 104'(done_o), 104'(0));
        chk("reset_prog", 104'(progress_done_o), 104'(0));
        q.delete();
        mr = 0;
        mc = 0;
        flush_left = 0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // Monitor: pop and compare on every done_o, check holds in gaps.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            last_t = '0;
        end else if (done_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done @cyc %0d: got done_o=1 want no output", cyc);
            end else begin
                e = q.pop_front();
                chk("taps", 104'(dut_t), 104'(e.t));
                chk("progress", 104'(progress_done_o), 104'(e.prog));
                chk("latency", 104'(cyc), 104'(e.at));
                last_t = e.t;
            end
        end else begin
            chk("hold_taps", 104'(dut_t), 104'(last_t));
            chk("idle_progress", 104'(progress_done_o), 104'(0));
            if (q.size() > 0 && q[0].at <= 32'(cyc)) begin
                checks++;
                errors++;
                $display("FAIL missing_done @cyc %0d: got done_o=0 want taps %h", cyc, q[0].t);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int f0;
        int n;
        repeat (3) @(negedge clk);
        chk("init_taps", 104'(dut_t), 104'(0));
        chk("init_done", 104'(done_o), 104'(0));
        chk("init_prog", 104'(progress_done_o), 104'(0));
        #2 rst = 1'b1;

        // Partial random frame, then reset mid-frame.
        for (int i = 0; i < 40; i++)
            send(($urandom_range(0, 9) < 7), 8'($urandom));
        do_reset();

        // Full continuous frame, pixel = row*16+col.
        f0 = frame_cnt;
        n  = 0;
        while (frame_cnt == f0 && n < 2000) begin
            send(1'b1, 8'(mr * 16 + mc));
            n++;
        end

        // Back-to-back frame with done_i toggling every cycle.
        f0 = frame_cnt;
        n  = 0;
        while (frame_cnt == f0 && n < 4000) begin
            send(1'b1, 8'(mr * 16 + mc));
            send(1'b0, 8'($urandom));
            n++;
        end

        // Random density, random pixels, one frame plus idle gap.
        f0 = frame_cnt;
        n  = 0;
        while (frame_cnt == f0 && n < 4000) begin
            send(($urandom_range(0, 3) != 0), 8'($urandom));
            n++;
        end
        for (int i = 0; i < 30; i++)
            send(($urandom_range(0, 1) == 1), 8'($urandom));
        n = 0;
        while (flush_left > 0 && n < 200) begin
            send(1'b1, 8'($urandom));
            n++;
        end
        do_reset();
        for (int i = 0; i < 20; i++)
            send(1'b1, 8'($urandom));

        n = 0;
        while (q.size() > 0 && n < 300) begin
            send(1'b0, 8'd0);
            n++;
        end
        send(1'b0, 8'd0);
        chk("drained", 104'(q.size()), 104'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/r6_column_tap_gen.md
Name: r6_column_tap_gen

Overview:
- Upstream producer for the R6 13-tap patch-sum stage.
- Accepts a raster pixel stream, one 8-bit pixel per done_i strobe, row-major, COLS pixels per row and ROWS rows per frame.
- Buffers the 12 previous rows on-chip. For every accepted pixel it emits the 13-pixel vertical column ending at that pixel on S1..S13, with a done_o strobe the patch-sum stage consumes directly.
- Signals end of frame on progress_done_o.

Parameters:
- COLS, 15, pixels per row; column counter width is clog2(COLS), minimum 1.
- ROWS, 15, rows per frame; must be 13 or more.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- done_i, input, 1, pixel-valid strobe; one pixel per high cycle.
- pixel_i, input, 8, pixel value, sampled when done_i=1.
- S1..S13, output, 8 each, column taps. S13 is the current row, S12 is row-1, …, S1 is row-12.
- done_o, output, 1, taps-valid strobe, one per emitted column.
- progress_done_o, output, 1, single-cycle end-of-frame pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - S1..S13=0, done_o=0, progress_done_o=0.
  - col_cnt=0, row_cnt=0, state=IDLE.
  - Line memory contents are not reset. Invalid taps are masked by row_cnt instead.
- Storage: 12 line buffers, each COLS x 8, addressed by col_cnt; lb[0] holds the oldest row.
- Accept, when done_i=1 in IDLE or STREAM, with c=col_cnt and r=row_cnt:
  - Registered outputs, 1-cycle latency: done_o=1 in the next cycle. S13=pixel_i, and S(13-k)=lb[12-k][c] for k=1..12.
  - Row masking: S(13-k) is forced to 0 when k>r. Row r-k does not exist yet, which gives top-edge zero padding.
  - Buffer update, same edge: lb[j][c] <= lb[j+1][c] for j=0..10, and lb[11][c] <= pixel_i. Read-before-write semantics; old values are emitted.
- Counters:
  - col_cnt wraps COLS-1 -> 0 and then increments row_cnt.
  - row_cnt counts 0..ROWS-1 (plus flush rows when enabled).
- done_i=0: done_o=0 next cycle. S1..S13 hold their last values. No state change.
- State machine:
  - IDLE -> STREAM on the first done_i.
  - STREAM -> DONE on accepting the pixel with c=COLS-1, r=ROWS-1 (flush disabled).
  - DONE: progress_done_o=1 for exactly one cycle, aligned with the last done_o. Then return to IDLE with counters cleared, ready for the next frame.
  - Back-to-back frames: a done_i in the DONE cycle is accepted as pixel (0,0) of the next frame. There is no bubble and no lost pixel.
- done_i during FLUSH is ignored: no accept, no buffer write.
- Reset mid-frame: immediate return to IDLE, outputs 0. The next frame restarts at (0,0) and masking uses the fresh row_cnt.
- Throughput: 1 pixel/cycle sustained. No backpressure; the downstream stage always accepts.

Optional Feature:
- Macro R6_TAP_FLUSH_EN.
- Defined:
  - After the last frame pixel, STREAM -> FLUSH instead of DONE.
  - FLUSH self-generates 6*COLS additional columns at 1/cycle, treating pixel_i as 0. Buffers shift exactly as for a real accept, which provides bottom-edge zero padding for a centred 13-row window.
  - done_o pulses for each flush column.
  - progress_done_o is aligned with the final flush column's done_o, then the block returns to IDLE.
- Undefined: no FLUSH state; behaviour is exactly as described above.

Test Plan:
- Reset with rst=0 mid-stream (COLS=15, ROWS=15) -> all outputs 0 in the same cycle. After release, the first pixel gives S13=pixel, S1..S12=0.
- Continuous frame with pixel=(row*16+col): pixel (row 3, col 5)=53 -> done_o next cycle. S13=53, S12=37, S11=21, S10=5, S1..S9=0.
- Same frame, pixel (row 14, col 2)=226 -> S13=226, S12=210, …, S1=(2*16+2)=34. No masking.
- done_i toggling 1/0 every cycle -> done_o toggles with 1-cycle lag. Outputs hold during gaps; tap values match the continuous-stream case.
- Last pixel (14,14) -> done_o and progress_done_o both high in the same cycle, exactly one pulse. A pixel in the next cycle is emitted as (0,0) with S1..S12=0.
- With R6_TAP_FLUSH_EN:
  - Last pixel -> 90 further done_o pulses with S13=0.
  - Flush column 0 (first flush row): S12=224, S1=(3*16+0)=48.
  - progress_done_o on the 90th pulse only.
  - done_i asserted during flush is ignored.
